pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the 16-bit MIPS core's fetch stage. It holds the current PC and selects the next PC from sequential increment, branch, jump/call, return, or pipeline flush, and it honours stall. An internal return-address stack (RAS) serves call/return. The unit replaces the bare PC register and drives the instruction-memory address directly.

## Interface

Parameters:
- PC_SIZE, 13, PC width in bits (word-addressed instruction memory).
- RAS_DEPTH, 4, number of return-address stack entries (≥2, power of two).
- RESET_VECTOR, 0, PC value loaded on reset (PC_SIZE bits).

Ports (reset is synchronous and active-high, sampled on the rising edge of clk):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- stall, in, 1, hold all state (PC, RAS, error flag).
- flush, in, 1, redirect to flush_target.
- flush_target, in, PC_SIZE, redirect address.
- branch_taken, in, 1, take branch_target.
- branch_target, in, PC_SIZE, branch destination.
- jump, in, 1, take jump_target.
- call, in, 1, push return address and take jump_target.
- jump_target, in, PC_SIZE, jump/call destination.
- ret, in, 1, pop the RAS and take the popped address.
- pc_current, out, PC_SIZE, registered current PC.
- pc_next, out, PC_SIZE, combinational value loaded at the next edge.
- ras_count, out, clog2(RAS_DEPTH)+1, valid RAS entries.
- ras_err, out, 1, sticky flag set on RAS overflow or underflow.

## Operation

- pc_plus1 = (pc_current + 1) mod 2^PC_SIZE. 2^PC_SIZE−1 wraps to 0 with no flag.
- Priority per cycle, highest first: rst > flush > stall > ret > call > jump > branch_taken > increment.
- rst: pc_current←RESET_VECTOR, ras_count←0, ras_err←0, RAS entries don't-care.
- flush: pc←flush_target. RAS and ras_err unchanged. Flush overrides stall.
- stall (no flush): nothing changes, and pc_next = pc_current.
- ret, ras_count>0: pc←top entry, ras_count−1.
- ret, ras_count=0 (underflow): pc←pc_plus1, ras_err←1, count stays 0.
- call: push pc_plus1, pc←jump_target.
  - If not full, ras_count+1.
  - If full, the oldest entry is discarded (circular), count stays RAS_DEPTH, ras_err←1.
- call and ret together: ret wins and no push occurs.
- jump: pc←jump_target. branch_taken: pc←branch_target. Otherwise pc←pc_plus1.
- Lower-priority requests in the same cycle are dropped; the unit does not queue them.
- RAS is implemented as a circular buffer with top pointer plus count. After an overflow, RAS_DEPTH pops return the RAS_DEPTH most recent pushes in LIFO order.

## Timing

- Every output is registered except pc_next, which is combinational from inputs and state with no clock in the path.
- Redirect latency is 1 cycle: a request sampled at edge N appears on pc_current after edge N.
- Reset values:
  - pc_current=RESET_VECTOR
  - ras_count=0
  - ras_err=0
  - pc_next=RESET_VECTOR+1 while rst is deasserted and no request is present
- rst asserted mid-call/ret discards the operation. The RAS is empty the following cycle.
- ras_err stays high until rst.

## Test plan

- Reset then 5 idle cycles with RESET_VECTOR=0 → pc_current 0,1,2,3,4,5; ras_count=0; ras_err=0.
- pc_current=0x1FFF, idle → pc_current=0x0000, ras_err=0.
- At pc 0x010, call to 0x100, call at 0x100 to 0x200, ret, ret → pc sequence 0x100, 0x200, 0x101, 0x011; ras_count 1, 2, 1, 0.
- RAS_DEPTH=4: five calls from pcs 0x10..0x14 then five rets → returns 0x15, 0x14, 0x13, 0x12; fifth ret gives pc_plus1 and ras_err=1 (set earlier at fifth call).
- stall=1 for 3 cycles with jump=1 → pc frozen. Then flush=1 with stall=1 and flush_target=0x0AA → pc_current=0x0AA next cycle, ras_count unchanged.
- call=ret=1 with 1 RAS entry 0x050 → pc=0x050, ras_count=0. Branch and jump together → jump_target taken.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with next-PC select and return-address stack.
// Ports: clk, rst (sync, active-high), stall, flush/flush_target,
//   branch_taken/branch_target, jump, call, jump_target, ret,
//   pc_current (reg), pc_next (comb), ras_count (reg), ras_err (reg, sticky).
module pc_unit #(
    parameter int PC_SIZE = 13,
    parameter int RAS_DEPTH = 4,
    parameter logic [PC_SIZE-1:0] RESET_VECTOR = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           flush,
    input  logic [PC_SIZE-1:0]             flush_target,
    input  logic                           branch_taken,
    input  logic [PC_SIZE-1:0]             branch_target,
    input  logic                           jump,
    input  logic                           call,
    input  logic [PC_SIZE-1:0]             jump_target,
    input  logic                           ret,
    output logic [PC_SIZE-1:0]             pc_current,
    output logic [PC_SIZE-1:0]             pc_next,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_err
);

    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [PC_SIZE-1:0] ras [RAS_DEPTH];
    logic [AW-1:0]      top;
    logic [PC_SIZE-1:0] pc_plus1;
    logic               push;
    logic               pop;
    logic               err_set;
    logic               full;

    assign pc_plus1 = pc_current + PC_SIZE'(1);
    assign full     = (ras_count == FULL);

    // Priority: rst > flush > stall > ret > call > jump > branch > increment.
    always_comb begin
        pc_next = pc_plus1;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (rst) begin
            pc_next = RESET_VECTOR;
        end else if (flush) begin
            pc_next = flush_target;
        end else if (stall) begin
            pc_next = pc_current;
        end else if (ret) begin
            if (ras_count != '0) begin
                pc_next = ras[top];
                pop     = 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end else if (call) begin
            pc_next = jump_target;
            push    = 1'b1;
            err_set = full;
        end else if (jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_current <= RESET_VECTOR;
            ras_count  <= '0;
            ras_err    <= 1'b0;
            top        <= '0;
        end else begin
            pc_current <= pc_next;
            // A push on a full stack advances the pointer over the oldest
            // entry, so the count saturates while LIFO order is preserved.
            if (push) begin
                top <= top + AW'(1);
                if (!full) begin
                    ras_count <= ras_count + CW'(1);
                end
            end else if (pop) begin
                top       <= top - AW'(1);
                ras_count <= ras_count - CW'(1);
            end
            if (err_set) begin
                ras_err <= 1'b1;
            end
        end
    end

    // Entries carry no reset; they are only read when ras_count says valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras[top + AW'(1)] <= pc_plus1;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table plus hand sequences for pc_unit.
// Checks pc_next before each edge and pc_current/ras_count/ras_err after.
module tb_pc_unit;

    localparam int PCW = 13;

    logic           clk;
    logic           rst;
    logic           stall;
    logic           flush;
    logic [PCW-1:0] flush_target;
    logic           branch_taken;
    logic [PCW-1:0] branch_target;
    logic           jump;
    logic           call;
    logic [PCW-1:0] jump_target;
    logic           ret;
    logic [PCW-1:0] pc_current;
    logic [PCW-1:0] pc_next;
    logic [2:0]     ras_count;
    logic           ras_err;

    int n_cmp;
    int n_bad;
    int step_no;

    pc_unit #(.PC_SIZE(PCW), .RAS_DEPTH(4), .RESET_VECTOR('0)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .flush_target(flush_target),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .call(call),
        .jump_target(jump_target),
        .ret(ret),
        .pc_current(pc_current),
        .pc_next(pc_next),
        .ras_count(ras_count),
        .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic           flush;
        logic           stall;
        logic           ret;
        logic           call;
        logic           jump;
        logic           br;
        logic [PCW-1:0] ft;
        logic [PCW-1:0] jt;
        logic [PCW-1:0] bt;
        logic [PCW-1:0] epc;
        logic [2:0]     ecnt;
        logic           eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic f, input logic s, input logic rt,
        input logic c, input logic j, input logic b,
        input logic [PCW-1:0] ft, input logic [PCW-1:0] jt,
        input logic [PCW-1:0] bt, input logic [PCW-1:0] epc,
        input logic [2:0] ecnt, input logic eerr);
        vec_t v;
        v.rst = r; v.flush = f; v.stall = s; v.ret = rt;
        v.call = c; v.jump = j; v.br = b;
        v.ft = ft; v.jt = jt; v.bt = bt;
        v.epc = epc; v.ecnt = ecnt; v.eerr = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h",
                     name, step_no, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst           = v.rst;
        flush         = v.flush;
        stall         = v.stall;
        ret           = v.ret;
        call          = v.call;
        jump          = v.jump;
        branch_taken  = v.br;
        flush_target  = v.ft;
        jump_target   = v.jt;
        branch_target = v.bt;
        #1;
        check("pc_next", 32'(pc_next), 32'(v.epc));
        @(posedge clk);
        #1;
        check("pc_current", 32'(pc_current), 32'(v.epc));
        check("ras_count", 32'(ras_count), 32'(v.ecnt));
        check("ras_err", 32'(ras_err), 32'(v.eerr));
        step_no++;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        step_no = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; ret = 1'b0;
        call = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        flush_target = '0; jump_target = '0; branch_target = '0;

        //             rst f s rt c j b  ft      jt      bt      epc     cnt err
        vecs.push_back(mk(1,0,0,0,0,0,0, 13'h0,  13'h0,  13'h0,  13'h000, 0, 0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0,0,0,0,0,0,0, 13'h0, 13'h0, 13'h0, PCW'(i), 0, 0));
        // nested call / return
        vecs.push_back(mk(0,1,0,0,0,0,0, 13'h010, 13'h0,   13'h0, 13'h010, 0, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 13'h0,   13'h100, 13'h0, 13'h100, 1, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 13'h0,   13'h200, 13'h0, 13'h200, 2, 0));
        vecs.push_back(mk(0,0,0,1,0,0,0, 13'h0,   13'h0,   13'h0, 13'h101, 1, 0));
        vecs.push_back(mk(0,0,0,1,0,0,0, 13'h0,   13'h0,   13'h0, 13'h011, 0, 0));
        // overflow: pushes 0x11..0x15, oldest dropped
        vecs.push_back(mk(0,1,0,0,0,0,0, 13'h010, 13'h0,   13'h0, 13'h010, 0, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 13'h0,   13'h011, 13'h0, 13'h011, 1, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 13'h0,   13'h012, 13'h0, 13'h012, 2, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 13'h0,   13'h013, 13'h0, 13'h013, 3, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 13'h0,   13'h014, 13'h0, 13'h014, 4, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 13'h0,   13'h015, 13'h0, 13'h015, 4, 1));
        vecs.push_back(mk(0,0,0,1,0,0,0, 13'h0,   13'h0,   13'h0, 13'h015, 3, 1));
        vecs.push_back(mk(0,0,0,1,0,0,0, 13'h0,   13'h0,   13'h0, 13'h014, 2, 1));
        vecs.push_back(mk(0,0,0,1,0,0,0, 13'h0,   13'h0,   13'h0, 13'h013, 1, 1));
        vecs.push_back(mk(0,0,0,1,0,0,0, 13'h0,   13'h0,   13'h0, 13'h012, 0, 1));
        vecs.push_back(mk(0,0,0,1,0,0,0, 13'h0,   13'h0,   13'h0, 13'h013, 0, 1));
        // stall holds, flush beats stall
        vecs.push_back(mk(1,0,0,0,0,0,0, 13'h0,   13'h0,   13'h0, 13'h000, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,1,0,0,1,0, 13'h0, 13'h300, 13'h0, 13'h000, 0, 0));
        vecs.push_back(mk(0,1,1,0,0,0,0, 13'h0AA, 13'h0,   13'h0, 13'h0AA, 0, 0));
        // call+ret: ret wins
        vecs.push_back(mk(0,1,0,0,0,0,0, 13'h04F, 13'h0,   13'h0, 13'h04F, 0, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 13'h0,   13'h123, 13'h0, 13'h123, 1, 0));
        vecs.push_back(mk(0,0,0,1,1,0,0, 13'h0,   13'h3FF, 13'h0, 13'h050, 0, 0));
        // jump beats branch, then branch alone, then increment
        vecs.push_back(mk(0,0,0,0,0,1,1, 13'h0,   13'h222, 13'h333, 13'h222, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 13'h0,   13'h0,   13'h333, 13'h333, 0, 0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 13'h0,   13'h0,   13'h0,   13'h334, 0, 0));

        foreach (vecs[i]) step(vecs[i]);

        // PC wraps from all-ones to zero without flagging
        step(mk(0,1,0,0,0,0,0, 13'h1FFF, 13'h0, 13'h0, 13'h1FFF, 0, 0));
        step(mk(0,0,0,0,0,0,0, 13'h0,    13'h0, 13'h0, 13'h0000, 0, 0));

        // stall freezes a pending ret; reset during call empties the RAS
        step(mk(0,0,0,0,1,0,0, 13'h0, 13'h040, 13'h0, 13'h040, 1, 0));
        step(mk(0,0,0,0,1,0,0, 13'h0, 13'h080, 13'h0, 13'h080, 2, 0));
        step(mk(0,0,1,1,0,0,0, 13'h0, 13'h0,   13'h0, 13'h080, 2, 0));
        step(mk(1,0,0,0,1,0,0, 13'h0, 13'h500, 13'h0, 13'h000, 0, 0));
        step(mk(0,0,0,1,0,0,0, 13'h0, 13'h0,   13'h0, 13'h001, 0, 1));

        // error stays set through flush and stall
        step(mk(0,1,0,0,0,0,0, 13'h077, 13'h0, 13'h0, 13'h077, 0, 1));
        step(mk(0,0,1,0,0,0,0, 13'h0,   13'h0, 13'h0, 13'h077, 0, 1));
        step(mk(0,0,0,0,0,0,0, 13'h0,   13'h0, 13'h0, 13'h078, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
